// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised Moore serial-pattern detector.
// A PAT_W-bit history shift register plus a fill counter form the detector
// state. Detection can be overlapping or non-overlapping (chosen at run time).
// Only cycles with enable=1 take a sample. A saturating counter tallies the
// matches and can be cleared synchronously. Every output is a flop.
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sequence_in,
    input  logic             overlap_mode,
    input  logic             clear_count,
    output logic             detector_out,
    output logic [CNT_W-1:0] match_count,
    output logic [4:0]       fill_level
);

    // fill_level is 5 bits wide, so it can hold any PAT_W from 2 to 16.
    localparam logic [4:0]       FILL_MAX = 5'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Classify the fill counter. Encodings above PAT_W are illegal.
    // An illegal encoding is sent back to the reset state.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2,
        ST_ILLEGAL = 2'd3
    } fill_state_t;

    // Add one to the counter, but hold it at the all-ones value (no wrap).
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = CNT_MAX;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    // Add one to the fill counter, but never go above the pattern length.
    function automatic logic [4:0] fill_advance(input logic [4:0] value);
        logic [4:0] result;
        if (value >= FILL_MAX) begin
            result = FILL_MAX;
        end else begin
            result = value + 5'd1;
        end
        return result;
    endfunction

    logic [PAT_W-1:0] hist_r;
    logic [4:0]       fill_r;
    logic             det_r;
    logic [CNT_W-1:0] cnt_r;

    logic [PAT_W-1:0] hist_s;
    logic [PAT_W-1:0] hist_shift_s;
    logic [4:0]       fill_s;
    logic [4:0]       fill_inc_s;
    logic             hit_s;
    logic             det_s;
    logic [CNT_W-1:0] cnt_s;
    fill_state_t      fill_state_s;

    // Shift the history and advance the fill counter as if this cycle takes a sample.
    always_comb begin
        hist_shift_s = {hist_r[PAT_W-2:0], sequence_in};
        fill_inc_s   = fill_advance(fill_r);
    end

    // Decode the fill counter into a detector state class.
    always_comb begin
        fill_state_s = ST_ILLEGAL;
        if (fill_r == 5'd0) begin
            fill_state_s = ST_EMPTY;
        end else if (fill_r < FILL_MAX) begin
            fill_state_s = ST_PARTIAL;
        end else if (fill_r == FILL_MAX) begin
            fill_state_s = ST_FULL;
        end else begin
            fill_state_s = ST_ILLEGAL;
        end
    end

    // Work out the next state, the match flag and the counter update.
    always_comb begin
        hist_s = hist_r;
        fill_s = fill_r;
        hit_s  = 1'b0;
        det_s  = 1'b0;
        cnt_s  = cnt_r;

        case (fill_state_s)
            ST_EMPTY, ST_PARTIAL, ST_FULL: begin
                if (enable) begin
                    hist_s = hist_shift_s;
                    hit_s  = (fill_inc_s == FILL_MAX) && (hist_shift_s == PATTERN);
                    // Non-overlap mode needs PAT_W fresh bits after a hit.
                    // Restarting the fill count makes the old history bits ignored.
                    if (hit_s && !overlap_mode) begin
                        fill_s = 5'd0;
                    end else begin
                        fill_s = fill_inc_s;
                    end
                end else begin
                    hist_s = hist_r;
                    fill_s = fill_r;
                end
            end
            default: begin
                hist_s = {PAT_W{1'b0}};
                fill_s = 5'd0;
            end
        endcase

        det_s = hit_s;

        // If clear and a hit come together, the clear wins and the hit is dropped.
        if (clear_count) begin
            cnt_s = {CNT_W{1'b0}};
        end else if (hit_s) begin
            cnt_s = sat_inc(cnt_r);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Register the state, the flag and the counter. Reset is asynchronous.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist_r <= {PAT_W{1'b0}};
            fill_r <= 5'd0;
            det_r  <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            hist_r <= hist_s;
            fill_r <= fill_s;
            det_r  <= det_s;
            cnt_r  <= cnt_s;
        end
    end

    // Drive the outputs straight from flops, so no path runs from inputs to outputs.
    always_comb begin
        detector_out = det_r;
        match_count  = cnt_r;
        fill_level   = fill_r;
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param. Three instances share the inputs:
//   a: 4-bit pattern 1011 with an 8-bit counter
//   b: 4-bit pattern 1011 with a 2-bit counter (saturation)
//   c: 8-bit pattern A5 with an 8-bit counter
// A reference model pushes the expected outputs of every instance into a
// scoreboard when it drives each sample. Directed expectations join the same
// queue. After the clock edge the entries are popped and compared.
module tb_seq_detector_param;

    logic clock;
    logic reset_n;
    logic enable;
    logic sequence_in;
    logic overlap_mode;
    logic clear_count;

    logic       det_a, det_b, det_c;
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;
    logic [4:0] fill_a, fill_b, fill_c;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string tag;
        int    idx;
        int    det;
        int    cnt;
        int    fill;
    } exp_t;

    exp_t sb[$];

    // Per-instance parameters and state of the reference model.
    int m_pw[3]   = '{4, 4, 8};
    int m_pat[3]  = '{11, 11, 165};
    int m_cmax[3] = '{255, 3, 255};
    int m_hist[3];
    int m_fill[3];
    int m_det[3];
    int m_cnt[3];

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
        .clock(clock), .reset_n(reset_n), .enable(enable), .sequence_in(sequence_in),
        .overlap_mode(overlap_mode), .clear_count(clear_count),
        .detector_out(det_a), .match_count(cnt_a), .fill_level(fill_a));

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .enable(enable), .sequence_in(sequence_in),
        .overlap_mode(overlap_mode), .clear_count(clear_count),
        .detector_out(det_b), .match_count(cnt_b), .fill_level(fill_b));

    seq_detector_param #(.PAT_W(8), .PATTERN(8'hA5), .CNT_W(8)) dut_c (
        .clock(clock), .reset_n(reset_n), .enable(enable), .sequence_in(sequence_in),
        .overlap_mode(overlap_mode), .clear_count(clear_count),
        .detector_out(det_c), .match_count(cnt_c), .fill_level(fill_c));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic read_dut(input int idx, output logic [31:0] d, output logic [31:0] c,
                            output logic [31:0] f);
        case (idx)
            0: begin d = {31'd0, det_a}; c = {24'd0, cnt_a}; f = {27'd0, fill_a}; end
            1: begin d = {31'd0, det_b}; c = {30'd0, cnt_b}; f = {27'd0, fill_b}; end
            default: begin d = {31'd0, det_c}; c = {24'd0, cnt_c}; f = {27'd0, fill_c}; end
        endcase
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_hist[i] = 0; m_fill[i] = 0; m_det[i] = 0; m_cnt[i] = 0;
        end
    endfunction

    // Reference behaviour for one clock edge of instance i.
    function automatic void model_step(int i, bit en, bit din, bit ov, bit clr);
        bit hit = 1'b0;
        if (en) begin
            m_hist[i] = ((m_hist[i] << 1) | int'(din)) & ((1 << m_pw[i]) - 1);
            m_fill[i] = (m_fill[i] + 1 > m_pw[i]) ? m_pw[i] : m_fill[i] + 1;
            hit = (m_fill[i] == m_pw[i]) && (m_hist[i] == m_pat[i]);
            if (hit && !ov) m_fill[i] = 0;
        end
        m_det[i] = int'(hit);
        if (clr) m_cnt[i] = 0;
        else if (hit && m_cnt[i] < m_cmax[i]) m_cnt[i] = m_cnt[i] + 1;
    endfunction

    task automatic expect_on(input string tag, input int idx, input int det,
                             input int cnt, input int fill);
        exp_t e;
        e.tag = tag; e.idx = idx; e.det = det; e.cnt = cnt; e.fill = fill;
        sb.push_back(e);
    endtask

    // Drive one cycle, step the model, wait for the edge, then drain the scoreboard.
    task automatic cycle(input logic en, input logic din, input logic ov, input logic clr);
        logic [31:0] d, c, f;
        exp_t e;
        enable = en; sequence_in = din; overlap_mode = ov; clear_count = clr;
        for (int i = 0; i < 3; i++) begin
            model_step(i, en, din, ov, clr);
            expect_on($sformatf("mdl%0d", i), i, m_det[i], m_cnt[i], m_fill[i]);
        end
        @(posedge clock);
        @(negedge clock);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_dut(e.idx, d, c, f);
            if (e.det >= 0)  check({e.tag, "_det"}, d, e.det);
            if (e.cnt >= 0)  check({e.tag, "_cnt"}, c, e.cnt);
            if (e.fill >= 0) check({e.tag, "_fill"}, f, e.fill);
        end
    endtask

    task automatic do_reset();
        logic [31:0] d, c, f;
        @(negedge clock);
        reset_n = 1'b0;
        sb.delete();
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            read_dut(i, d, c, f);
            check($sformatf("rst%0d_det", i), d, 0);
            check($sformatf("rst%0d_cnt", i), c, 0);
            check($sformatf("rst%0d_fill", i), f, 0);
        end
        enable = 1'b1; sequence_in = 1'b1;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            read_dut(i, d, c, f);
            check($sformatf("rst_hold%0d_det", i), d, 0);
            check($sformatf("rst_hold%0d_fill", i), f, 0);
        end
        enable = 1'b0; sequence_in = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [6:0]  s7;
        logic [6:0]  exp_det;
        logic [15:0] s16;
        logic [7:0]  pat_c;
        logic        en_r, din_r, clr_r;
        int          pos;

        reset_n = 1'b0; enable = 1'b0; sequence_in = 1'b0;
        overlap_mode = 1'b0; clear_count = 1'b0;
        do_reset();

        // T1: reset with 3 of 4 bits matched, then one more 1 -> no detection.
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        do_reset();
        expect_on("t1", 0, 0, 0, 1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);

        // T2: overlapping, stream 1011011 -> pulses after bits 4 and 7.
        do_reset();
        s7 = 7'b1011011; exp_det = 7'b0001001;
        for (int i = 0; i < 7; i++) begin
            expect_on($sformatf("t2_b%0d", i + 1), 0, int'(exp_det[6-i]), -1, -1);
            cycle(1'b1, s7[6-i], 1'b1, 1'b0);
        end
        check("t2_cnt", {24'd0, cnt_a}, 2);

        // T3: non-overlapping, same stream -> single pulse, fill ends at 3.
        do_reset();
        exp_det = 7'b0001000;
        for (int i = 0; i < 7; i++) begin
            expect_on($sformatf("t3_b%0d", i + 1), 0, int'(exp_det[6-i]), -1, -1);
            cycle(1'b1, s7[6-i], 1'b0, 1'b0);
        end
        check("t3_cnt", {24'd0, cnt_a}, 1);
        check("t3_fill", {27'd0, fill_a}, 3);

        // T4: three enable=0 gap cycles with toggling data between bits 2 and 3.
        do_reset();
        expect_on("t4_b1", 0, 0, -1, 1);   cycle(1'b1, 1'b1, 1'b1, 1'b0);
        expect_on("t4_b2", 0, 0, -1, 2);   cycle(1'b1, 1'b0, 1'b1, 1'b0);
        expect_on("t4_gap1", 0, 0, -1, 2); cycle(1'b0, 1'b1, 1'b1, 1'b0);
        expect_on("t4_gap2", 0, 0, -1, 2); cycle(1'b0, 1'b0, 1'b1, 1'b0);
        expect_on("t4_gap3", 0, 0, -1, 2); cycle(1'b0, 1'b1, 1'b1, 1'b0);
        expect_on("t4_b3", 0, 0, -1, 3);   cycle(1'b1, 1'b1, 1'b1, 1'b0);
        expect_on("t4_b4", 0, 1, 1, 4);    cycle(1'b1, 1'b1, 1'b1, 1'b0);

        // T5: 2-bit counter saturates at 3, then a clear on a hit cycle.
        do_reset();
        s16 = 16'b1011011011011011;
        for (int i = 0; i < 16; i++) cycle(1'b1, s16[15-i], 1'b1, 1'b0);
        check("t5_sat", {30'd0, cnt_b}, 3);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        expect_on("t5_clr_hit", 1, 1, 0, 4);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);

        // T6: 1000 random bits for all instances, overlap then non-overlap.
        // The A5 pattern is embedded periodically so that hits occur.
        do_reset();
        pat_c = 8'hA5;
        for (int k = 0; k < 1000; k++) begin
            pos   = k % 40;
            en_r  = ($urandom_range(0, 9) != 0);
            clr_r = ($urandom_range(0, 199) == 0);
            if (pos < 8) din_r = pat_c[7-pos];
            else         din_r = 1'($urandom_range(0, 1));
            cycle(en_r, din_r, (k < 500) ? 1'b1 : 1'b0, clr_r);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
